// File: rtl/flash_read_checker_if.sv
// rtl/flash_read_checker_if.sv - arm/read-stream/result bundle for flash_read_checker
interface flash_read_checker_if #(
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_ERR_CNT_WIDTH = 16
);
  logic                       i_chk_start;
  logic [P_DATA_WIDTH-1:0]    i_chk_seed;
  logic [8:0]                 i_chk_num;
  logic [P_DATA_WIDTH-1:0]    i_read_data;
  logic                       i_read_sop;
  logic                       i_read_eop;
  logic                       i_read_valid;
  logic                       o_chk_busy;
  logic                       o_chk_done;
  logic                       o_chk_pass;
  logic                       o_len_err;
  logic [P_ERR_CNT_WIDTH-1:0] o_err_cnt;
  logic [8:0]                 o_first_err_idx;
  logic [P_DATA_WIDTH-1:0]    o_first_err_data;
  logic [8:0]                 o_byte_cnt;

  modport master (
    output i_chk_start, i_chk_seed, i_chk_num,
    output i_read_data, i_read_sop, i_read_eop, i_read_valid,
    input  o_chk_busy, o_chk_done, o_chk_pass, o_len_err,
    input  o_err_cnt, o_first_err_idx, o_first_err_data, o_byte_cnt
  );

  modport slave (
    input  i_chk_start, i_chk_seed, i_chk_num,
    input  i_read_data, i_read_sop, i_read_eop, i_read_valid,
    output o_chk_busy, o_chk_done, o_chk_pass, o_len_err,
    output o_err_cnt, o_first_err_idx, o_first_err_data, o_byte_cnt
  );
endinterface

// File: rtl/flash_read_checker.sv
// rtl/flash_read_checker.sv - compares a flash read stream against a seeded incrementing pattern
module flash_read_checker #(
  parameter int P_DATA_WIDTH    = 8,
  parameter int P_OP_MAX_LEN    = 256,
  parameter int P_ERR_CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  flash_read_checker_if.slave  bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOP = 2'd1;
  localparam logic [1:0] RECV     = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]                 state;
  logic [P_DATA_WIDTH-1:0]    seed;
  logic [8:0]                 num;
  logic [P_ERR_CNT_WIDTH-1:0] err_cnt;
  logic                       len_err;
  logic [8:0]                 byte_cnt;
  logic [8:0]                 first_idx;
  logic [P_DATA_WIDTH-1:0]    first_data;
  logic                       pass_q;

  logic                       start_ok;
  logic                       beat;
  logic [8:0]                 idx;
  logic [8:0]                 next_cnt;
  logic                       in_range;
  logic [P_DATA_WIDTH-1:0]    expected;
  logic                       mismatch;
  logic                       verdict;

  // Decode the current beat: arm qualification, byte index, expected value and compare result
  always_comb begin
    start_ok = bus.i_chk_start && (state == IDLE || state == DONE) &&
               (bus.i_chk_num != 9'd0) && (bus.i_chk_num <= 9'(P_OP_MAX_LEN));
    beat     = bus.i_read_valid &&
               ((state == WAIT_SOP && bus.i_read_sop) || state == RECV);
    // A sop always restarts the index, which resynchronises after a framing fault
    idx      = bus.i_read_sop ? 9'd0 : byte_cnt;
    next_cnt = (idx == 9'h1FF) ? idx : idx + 9'd1;
    in_range = idx < num;
    expected = seed + P_DATA_WIDTH'(idx);
    mismatch = in_range && (bus.i_read_data != expected);
    verdict  = (err_cnt == '0) && !len_err;
  end

  // Arm, per-beat scoreboard update and one-cycle DONE sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      seed       <= '0;
      num        <= '0;
      err_cnt    <= '0;
      len_err    <= 1'b0;
      byte_cnt   <= '0;
      first_idx  <= '0;
      first_data <= '0;
      pass_q     <= 1'b0;
    end else if (start_ok) begin
      state      <= WAIT_SOP;
      seed       <= bus.i_chk_seed;
      num        <= bus.i_chk_num;
      err_cnt    <= '0;
      len_err    <= 1'b0;
      byte_cnt   <= '0;
      first_idx  <= '0;
      first_data <= '0;
      pass_q     <= 1'b0;
    end else if (beat) begin
      byte_cnt <= next_cnt;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + P_ERR_CNT_WIDTH'(1);
        // A saturating counter never returns to zero, so zero means no mismatch seen yet
        if (err_cnt == '0) begin
          first_idx  <= idx;
          first_data <= bus.i_read_data;
        end
      end
      if (!in_range || (state == RECV && bus.i_read_sop) ||
          (bus.i_read_eop && next_cnt != num))
        len_err <= 1'b1;
      state <= bus.i_read_eop ? DONE : RECV;
    end else if (state == DONE) begin
      state  <= IDLE;
      pass_q <= verdict;
    end
  end

  assign bus.o_chk_busy       = (state == WAIT_SOP) || (state == RECV);
  assign bus.o_chk_done       = (state == DONE);
  assign bus.o_chk_pass       = (state == DONE) ? verdict : pass_q;
  assign bus.o_len_err        = len_err;
  assign bus.o_err_cnt        = err_cnt;
  assign bus.o_first_err_idx  = first_idx;
  assign bus.o_first_err_data = first_data;
  assign bus.o_byte_cnt       = byte_cnt;

endmodule

// File: tb/tb_flash_read_checker.sv
// tb/tb_flash_read_checker.sv - directed self-checking bench for flash_read_checker
module tb_flash_read_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   saved_done;

  flash_read_checker_if #(.P_DATA_WIDTH(8), .P_ERR_CNT_WIDTH(16)) bus ();

  flash_read_checker #(
    .P_DATA_WIDTH(8),
    .P_OP_MAX_LEN(256),
    .P_ERR_CNT_WIDTH(16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #50 clk = ~clk;

  always @(posedge clk) if (bus.o_chk_done) done_cnt <= done_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.i_read_valid = 1'b0;
    bus.i_read_sop   = 1'b0;
    bus.i_read_eop   = 1'b0;
  endtask

  task automatic arm(input logic [7:0] seed, input logic [8:0] num);
    @(negedge clk);
    bus.i_chk_start = 1'b1;
    bus.i_chk_seed  = seed;
    bus.i_chk_num   = num;
    @(negedge clk);
    bus.i_chk_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
    @(negedge clk);
    bus.i_read_valid = 1'b1;
    bus.i_read_data  = d;
    bus.i_read_sop   = sop;
    bus.i_read_eop   = eop;
  endtask

  task automatic close(input string tag);
    @(negedge clk);
    idle_bus();
    check({tag, "_done"}, 32'(bus.o_chk_done), 32'd1);
    check({tag, "_busy"}, 32'(bus.o_chk_busy), 32'd0);
  endtask

  initial begin
    bus.i_chk_start = 1'b0;
    bus.i_chk_seed  = '0;
    bus.i_chk_num   = '0;
    bus.i_read_data = '0;
    idle_bus();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",  32'(bus.o_chk_busy), 0);
    check("rst_done",  32'(bus.o_chk_done), 0);
    check("rst_pass",  32'(bus.o_chk_pass), 0);
    check("rst_len",   32'(bus.o_len_err), 0);
    check("rst_err",   32'(bus.o_err_cnt), 0);
    check("rst_cnt",   32'(bus.o_byte_cnt), 0);
    check("rst_fidx",  32'(bus.o_first_err_idx), 0);
    check("rst_fdata", 32'(bus.o_first_err_data), 0);

    arm(8'h10, 9'd4);
    check("clean_busy", 32'(bus.o_chk_busy), 1);
    beat(8'h10, 1, 0); beat(8'h11, 0, 0); beat(8'h12, 0, 0); beat(8'h13, 0, 1);
    close("clean");
    check("clean_pass", 32'(bus.o_chk_pass), 1);
    check("clean_err",  32'(bus.o_err_cnt), 0);
    check("clean_cnt",  32'(bus.o_byte_cnt), 4);
    check("clean_len",  32'(bus.o_len_err), 0);
    @(negedge clk);
    check("clean_done_off", 32'(bus.o_chk_done), 0);
    check("clean_pass_hold", 32'(bus.o_chk_pass), 1);

    arm(8'hFE, 9'd4);
    beat(8'hFE, 1, 0); beat(8'hFF, 0, 0); beat(8'h05, 0, 0); beat(8'h01, 0, 1);
    close("wrap");
    check("wrap_err",   32'(bus.o_err_cnt), 1);
    check("wrap_fidx",  32'(bus.o_first_err_idx), 2);
    check("wrap_fdata", 32'(bus.o_first_err_data), 32'h05);
    check("wrap_pass",  32'(bus.o_chk_pass), 0);

    arm(8'h20, 9'd3);
    beat(8'h20, 1, 0); beat(8'h21, 0, 1);
    close("short");
    check("short_len",  32'(bus.o_len_err), 1);
    check("short_cnt",  32'(bus.o_byte_cnt), 2);
    check("short_pass", 32'(bus.o_chk_pass), 0);

    arm(8'h30, 9'd2);
    beat(8'h30, 1, 0); beat(8'h31, 0, 0); beat(8'h32, 0, 1);
    close("long");
    check("long_len", 32'(bus.o_len_err), 1);
    check("long_cnt", 32'(bus.o_byte_cnt), 3);
    check("long_err", 32'(bus.o_err_cnt), 0);

    arm(8'h40, 9'd2);
    beat(8'h99, 0, 0); beat(8'h98, 0, 0);
    beat(8'h40, 1, 0);
    check("stray_cnt",  32'(bus.o_byte_cnt), 0);
    check("stray_busy", 32'(bus.o_chk_busy), 1);
    beat(8'h41, 0, 1);
    close("stray");
    check("stray_pass", 32'(bus.o_chk_pass), 1);
    check("stray_cnt2", 32'(bus.o_byte_cnt), 2);

    arm(8'h60, 9'd3);
    beat(8'h60, 1, 0); beat(8'h61, 0, 0); beat(8'h60, 1, 0); beat(8'h61, 0, 0); beat(8'h62, 0, 1);
    close("resop");
    check("resop_len",  32'(bus.o_len_err), 1);
    check("resop_cnt",  32'(bus.o_byte_cnt), 3);
    check("resop_err",  32'(bus.o_err_cnt), 0);
    check("resop_pass", 32'(bus.o_chk_pass), 0);

    arm(8'h55, 9'd1);
    beat(8'h55, 1, 1);
    @(negedge clk);
    idle_bus();
    check("one_done", 32'(bus.o_chk_done), 1);
    check("one_pass", 32'(bus.o_chk_pass), 1);
    check("one_cnt",  32'(bus.o_byte_cnt), 1);
    bus.i_chk_start = 1'b1;
    bus.i_chk_seed  = 8'h01;
    bus.i_chk_num   = 9'd1;
    @(negedge clk);
    bus.i_chk_start = 1'b0;
    check("rearm_busy", 32'(bus.o_chk_busy), 1);
    check("rearm_pass", 32'(bus.o_chk_pass), 0);
    check("rearm_cnt",  32'(bus.o_byte_cnt), 0);
    check("rearm_done", 32'(bus.o_chk_done), 0);
    beat(8'h01, 1, 1);
    close("rearm");
    check("rearm_pass2", 32'(bus.o_chk_pass), 1);

    arm(8'h33, 9'd0);
    check("num0_busy", 32'(bus.o_chk_busy), 0);
    @(negedge clk);
    check("num0_busy2", 32'(bus.o_chk_busy), 0);
    check("num0_pass",  32'(bus.o_chk_pass), 1);

    arm(8'h70, 9'd2);
    arm(8'h00, 9'd5);
    check("busy_start_busy", 32'(bus.o_chk_busy), 1);
    beat(8'h70, 1, 0); beat(8'h71, 0, 1);
    close("busy_start");
    check("busy_start_pass", 32'(bus.o_chk_pass), 1);
    check("busy_start_len",  32'(bus.o_len_err), 0);
    check("busy_start_cnt",  32'(bus.o_byte_cnt), 2);

    arm(8'h80, 9'd4);
    beat(8'h80, 1, 0); beat(8'h81, 0, 0);
    check("abort_cnt_pre", 32'(bus.o_byte_cnt), 1);
    #10;
    rst_n = 1'b0;
    idle_bus();
    #1;
    check("abort_busy", 32'(bus.o_chk_busy), 0);
    check("abort_cnt",  32'(bus.o_byte_cnt), 0);
    check("abort_pass", 32'(bus.o_chk_pass), 0);
    check("abort_len",  32'(bus.o_len_err), 0);
    saved_done = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_done", 32'(bus.o_chk_done), 0);
    end
    check("abort_done_cnt", 32'(done_cnt), 32'(saved_done));
    check("abort_busy2", 32'(bus.o_chk_busy), 0);

    arm(8'h00, 9'd256);
    for (int i = 0; i < 256; i++) beat(8'(i), i == 0, i == 255);
    close("max");
    check("max_pass", 32'(bus.o_chk_pass), 1);
    check("max_cnt",  32'(bus.o_byte_cnt), 256);
    check("max_err",  32'(bus.o_err_cnt), 0);
    check("max_len",  32'(bus.o_len_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_read_checker.md
# flash_read_checker

Self-checking consumer for the read-data stream that `flash_drive` produces. It arms on a start pulse with an expected byte pattern and length, then compares every received read byte against that pattern. It counts mismatches, records the first failing byte, detects packet-length faults, and reports a one-cycle done pulse with a pass/fail verdict. It sits beside `user_gen` on the 10 MHz system clock and lets hardware tests judge flash write/read round trips.

## Interface
- P_DATA_WIDTH, 8, read byte width
- P_OP_MAX_LEN, 256, maximum bytes per checked packet
- P_ERR_CNT_WIDTH, 16, width of the mismatch counter
- i_clk  in  1  system clock (10 MHz domain)
- i_rst_n  in  1  asynchronous, active-low reset
- i_chk_start  in  1  one-cycle arm pulse
- i_chk_seed  in  P_DATA_WIDTH  expected value of byte 0
- i_chk_num  in  9  expected byte count, 1..256
- i_read_data  in  P_DATA_WIDTH  read byte from flash_drive
- i_read_sop  in  1  first byte of packet, qualified by valid
- i_read_eop  in  1  last byte of packet, qualified by valid
- i_read_valid  in  1  byte strobe
- o_chk_busy  out  1  high from the accepted start until done
- o_chk_done  out  1  one-cycle completion pulse
- o_chk_pass  out  1  verdict; valid from done until the next accepted start
- o_len_err  out  1  packet length or framing fault
- o_err_cnt  out  P_ERR_CNT_WIDTH  data mismatch count; saturates at all-ones
- o_first_err_idx  out  9  index of the first mismatching byte
- o_first_err_data  out  P_DATA_WIDTH  received value at the first mismatch
- o_byte_cnt  out  9  bytes received in the current or last packet; saturates at 511

## Operation
- States: IDLE, WAIT_SOP, RECV, DONE.
- **IDLE/DONE + i_chk_start with i_chk_num != 0**
  - Latch seed and num.
  - Clear err_cnt, len_err, byte_cnt, first_err_* and pass.
  - Go to WAIT_SOP.
- **i_chk_start with num == 0:** ignored.
- **i_chk_start while busy:** ignored.
- **WAIT_SOP:**
  - Beats with valid && !sop are dropped and not counted.
  - valid && sop processes that beat as index 0, then goes to RECV. If eop is also set, it goes to DONE.
- **RECV:** each valid beat at index idx (equal to byte_cnt before increment):
  - If idx < num: expected = (seed + idx) mod 2^P_DATA_WIDTH.
  - On a mismatch, err_cnt increments (saturating). On the first mismatch only, capture idx and data.
  - If idx >= num: set len_err; the byte is not compared.
  - byte_cnt increments, saturating at 511.
  - A sop inside RECV sets len_err and restarts idx at 0 for that beat (resynchronisation).
- **eop beat:**
  - If final byte_cnt != num, set len_err.
  - Transition to DONE.
- **DONE (exactly 1 cycle):**
  - o_chk_done = 1.
  - o_chk_pass = (err_cnt == 0) && !len_err.
  - Next state is IDLE; results hold.
- A valid beat in IDLE or DONE is ignored.

## Timing
- Reset (async assert, sync-style release on i_clk):
  - State = IDLE.
  - o_chk_busy, o_chk_done, o_chk_pass and o_len_err = 0.
  - o_err_cnt, o_first_err_idx, o_first_err_data and o_byte_cnt = 0.
- Start sampled at edge N: o_chk_busy = 1 and state WAIT_SOP from N+1.
- Every valid beat is accepted; there is no backpressure.
- Compare is registered: o_err_cnt, o_byte_cnt and o_first_err_* reflect a beat 1 cycle after it.
- eop beat at edge M: o_chk_done = 1 and o_chk_pass valid during cycle M+1; o_chk_busy = 0 from M+1.
- Start coinciding with the DONE cycle is accepted: new arm, results cleared on the next edge.
- Reset mid-packet aborts immediately; no done pulse is issued.

## Test plan
- **Clean pass:** seed 0x10, num 4, stream 10,11,12,13 (sop on beat 0, eop on beat 3) -> done 1 cycle after eop; pass = 1, err_cnt = 0, byte_cnt = 4, len_err = 0.
- **Wrap and mismatch:** seed 0xFE, num 4, stream FE,FF,05,01 -> err_cnt = 1, first_err_idx = 2, first_err_data = 0x05, pass = 0.
- **Length faults:**
  - num 3 with eop on beat 2 of 2 -> len_err = 1, byte_cnt = 2, pass = 0.
  - num 2 with stream of 3 bytes -> len_err = 1, byte_cnt = 3.
- **Framing:**
  - Stray valid beats before sop -> ignored, byte_cnt unaffected.
  - sop+eop on the same beat with num 1 and a matching byte -> pass = 1.
  - A second sop inside RECV -> len_err = 1.
- **Control:**
  - num 0 start -> busy stays 0.
  - Start while busy -> ignored.
  - Reset asserted mid-packet -> all outputs 0, no done pulse.
- **Max length:** seed 0x00, num 256, stream of 256 bytes 00..FF -> pass = 1, byte_cnt = 256.
